// File: rtl/can_pkg.sv
// Shared CAN constants, frame field layout and receiver types.
package can_pkg;

    localparam logic [14:0] CAN_CRC_POLY = 15'h4599;

    localparam int unsigned ID_W        = 11;
    localparam int unsigned DLC_W       = 4;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned CRC_W       = 15;
    localparam int unsigned EOF_W       = 7;
    localparam int unsigned STUFF_LIMIT = 5;

    // Destuffed bit positions counted from the first bit after SOF.
    localparam int unsigned RTR_IDX    = ID_W;
    localparam int unsigned IDE_IDX    = ID_W + 1;
    localparam int unsigned R0_IDX     = ID_W + 2;
    localparam int unsigned DLC_IDX    = ID_W + 3;
    localparam int unsigned DATA_IDX   = DLC_IDX + DLC_W;
    localparam int unsigned CRC_IDX    = DATA_IDX + DATA_W;
    localparam int unsigned FRAME_BITS = CRC_IDX + CRC_W;

    localparam logic [DLC_W-1:0] DLC_EXPECTED = 4'd4;

    typedef enum logic [2:0] {
        StWaitIdle,
        StIdle,
        StSof,
        StRxStuffed,
        StCrcDelim,
        StAckSlot,
        StAckDelim,
        StEof
    } rx_state_e;

    typedef enum logic [1:0] {
        ERR_STUFF = 2'd0,
        ERR_CRC   = 2'd1,
        ERR_FORM  = 2'd2
    } err_code_e;

endpackage

// File: rtl/can_crc15.sv
// Serial CAN CRC-15 accumulator, one bit per enable.
module can_crc15
    import can_pkg::*;
(
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             clear,
    input  logic             enable,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc_out
);

    logic [CRC_W-1:0] crc_q;
    logic [CRC_W-1:0] crc_d;
    logic             feedback;

    // Next CRC value for the incoming bit.
    always_comb begin
        feedback = bit_in ^ crc_q[CRC_W-1];
        crc_d    = {crc_q[CRC_W-2:0], 1'b0} ^ (feedback ? CAN_CRC_POLY : '0);
    end

    // CRC register: clear has priority over accumulation.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            crc_q <= '0;
        end else if (clear) begin
            crc_q <= '0;
        end else if (enable) begin
            crc_q <= crc_d;
        end
    end

    assign crc_out = crc_q;

endmodule

// File: rtl/can_bit_destuffer.sv
// CAN standard data frame receiver: SOF detection, destuffing and frame checks.
module can_bit_destuffer
    import can_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1000,
    parameter int unsigned IDLE_BITS    = 11
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              serial_i,
    output logic [ID_W-1:0]   msg_id_o,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              error_o,
    output logic [1:0]        error_code_o,
    output logic              busy_o
);

    localparam int unsigned TickW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IdleW = $clog2(IDLE_BITS + 1);

    localparam logic [TickW-1:0] TickHalf = TickW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TickW-1:0] TickFull = TickW'(CLKS_PER_BIT - 1);
    localparam logic [IdleW-1:0] IdleLast = IdleW'(IDLE_BITS - 1);

    localparam logic [6:0] IdxRtr     = 7'(RTR_IDX);
    localparam logic [6:0] IdxIde     = 7'(IDE_IDX);
    localparam logic [6:0] IdxR0      = 7'(R0_IDX);
    localparam logic [6:0] IdxDlc     = 7'(DLC_IDX);
    localparam logic [6:0] IdxData    = 7'(DATA_IDX);
    localparam logic [6:0] IdxCrc     = 7'(CRC_IDX);
    localparam logic [6:0] IdxDlcLast = 7'(DATA_IDX - 1);
    localparam logic [6:0] IdxCrcLast = 7'(FRAME_BITS - 1);
    localparam logic [6:0] IdxEnd     = 7'(FRAME_BITS);
    localparam logic [2:0] StuffRun   = 3'(STUFF_LIMIT);
    localparam logic [2:0] EofLast    = 3'(EOF_W - 1);

    rx_state_e         state_q;
    logic [1:0]        sync_q;
    logic              prev_q;
    logic [TickW-1:0]  tick_q;
    logic [IdleW-1:0]  idle_cnt_q;
    logic [6:0]        bit_cnt_q;
    logic [2:0]        run_cnt_q;
    logic              run_val_q;
    logic [2:0]        eof_cnt_q;
    logic [ID_W-1:0]   id_sh_q;
    logic [DLC_W-2:0]  dlc_sh_q;
    logic [DATA_W-1:0] data_sh_q;
    logic [CRC_W-2:0]  crc_sh_q;
    logic [ID_W-1:0]   msg_id_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              error_q;
    err_code_e         error_code_q;
    logic              busy_q;

    logic              rx_bit;
    logic              sample;
    logic              stuff_due;
    logic [2:0]        run_cnt_nxt;
    logic              crc_clear;
    logic              crc_enable;
    logic [CRC_W-1:0]  crc_val;
    logic              fault;
    err_code_e         fault_code;

    assign rx_bit      = sync_q[1];
    assign sample      = (tick_q == '0);
    assign stuff_due   = (run_cnt_q == StuffRun);
    assign run_cnt_nxt = (rx_bit == run_val_q) ? run_cnt_q + 3'd1 : 3'd1;

    // CRC covers SOF through the last data bit, destuffed bits only.
    assign crc_clear  = (state_q == StIdle);
    assign crc_enable = sample &&
                        ((state_q == StSof && !rx_bit) ||
                         (state_q == StRxStuffed && !stuff_due && bit_cnt_q < IdxCrc));

    can_crc15 u_crc (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .clear   (crc_clear),
        .enable  (crc_enable),
        .bit_in  (rx_bit),
        .crc_out (crc_val)
    );

    // Decode stuff, CRC and form violations at the sample of the offending bit.
    always_comb begin
        fault      = 1'b0;
        fault_code = ERR_FORM;
        if (sample) begin
            case (state_q)
                StRxStuffed: begin
                    if (stuff_due) begin
                        if (rx_bit == run_val_q) begin
                            fault      = 1'b1;
                            fault_code = ERR_STUFF;
                        end
                    end else if ((bit_cnt_q == IdxRtr || bit_cnt_q == IdxIde ||
                                  bit_cnt_q == IdxR0) && rx_bit) begin
                        fault = 1'b1;
                    end else if (bit_cnt_q == IdxDlcLast &&
                                 {dlc_sh_q, rx_bit} != DLC_EXPECTED) begin
                        fault = 1'b1;
                    end else if (bit_cnt_q == IdxCrcLast && {crc_sh_q, rx_bit} != crc_val) begin
                        fault      = 1'b1;
                        fault_code = ERR_CRC;
                    end
                end
                StCrcDelim, StAckDelim, StEof: fault = !rx_bit;
                default: ;
            endcase
        end
    end

    // Receiver FSM, bit timing, field capture and registered outputs.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q      <= StWaitIdle;
            sync_q       <= 2'b11;
            prev_q       <= 1'b1;
            tick_q       <= '0;
            idle_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            run_cnt_q    <= '0;
            run_val_q    <= 1'b0;
            eof_cnt_q    <= '0;
            id_sh_q      <= '0;
            dlc_sh_q     <= '0;
            data_sh_q    <= '0;
            crc_sh_q     <= '0;
            msg_id_q     <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            error_q      <= 1'b0;
            error_code_q <= ERR_STUFF;
            busy_q       <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], serial_i};
            prev_q  <= rx_bit;
            valid_q <= 1'b0;
            error_q <= 1'b0;
            tick_q  <= sample ? TickFull : tick_q - 1'b1;
            if (fault) begin
                error_q      <= 1'b1;
                error_code_q <= fault_code;
                busy_q       <= 1'b0;
                idle_cnt_q   <= '0;
                state_q      <= StWaitIdle;
            end else begin
                case (state_q)
                    StWaitIdle: if (sample) begin
                        if (!rx_bit) begin
                            idle_cnt_q <= '0;
                        end else if (idle_cnt_q == IdleLast) begin
                            idle_cnt_q <= '0;
                            state_q    <= StIdle;
                        end else begin
                            idle_cnt_q <= idle_cnt_q + 1'b1;
                        end
                    end
                    StIdle: if (prev_q && !rx_bit) begin
                        // Align the first sample to mid-bit of SOF.
                        tick_q  <= TickHalf;
                        busy_q  <= 1'b1;
                        state_q <= StSof;
                    end
                    StSof: if (sample) begin
                        if (!rx_bit) begin
                            run_val_q <= 1'b0;
                            run_cnt_q <= 3'd1;
                            bit_cnt_q <= '0;
                            state_q   <= StRxStuffed;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end
                    end
                    StRxStuffed: if (sample) begin
                        run_val_q <= rx_bit;
                        if (stuff_due) begin
                            run_cnt_q <= 3'd1;
                            if (bit_cnt_q == IdxEnd) state_q <= StCrcDelim;
                        end else begin
                            run_cnt_q <= run_cnt_nxt;
                            bit_cnt_q <= bit_cnt_q + 7'd1;
                            if (bit_cnt_q < IdxRtr) begin
                                id_sh_q <= {id_sh_q[ID_W-2:0], rx_bit};
                            end else if (bit_cnt_q >= IdxDlc && bit_cnt_q < IdxData) begin
                                dlc_sh_q <= {dlc_sh_q[DLC_W-3:0], rx_bit};
                            end else if (bit_cnt_q >= IdxData && bit_cnt_q < IdxCrc) begin
                                data_sh_q <= {data_sh_q[DATA_W-2:0], rx_bit};
                            end else if (bit_cnt_q >= IdxCrc) begin
                                crc_sh_q <= {crc_sh_q[CRC_W-3:0], rx_bit};
                            end
                            // A stuff bit owed after the last CRC bit is consumed here first.
                            if (bit_cnt_q == IdxCrcLast && run_cnt_nxt != StuffRun) begin
                                state_q <= StCrcDelim;
                            end
                        end
                    end
                    StCrcDelim: if (sample) state_q <= StAckSlot;
                    StAckSlot:  if (sample) state_q <= StAckDelim;
                    StAckDelim: if (sample) begin
                        eof_cnt_q <= '0;
                        state_q   <= StEof;
                    end
                    StEof: if (sample) begin
                        if (eof_cnt_q == EofLast) begin
                            msg_id_q   <= id_sh_q;
                            data_q     <= data_sh_q;
                            valid_q    <= 1'b1;
                            busy_q     <= 1'b0;
                            idle_cnt_q <= '0;
                            state_q    <= StWaitIdle;
                        end else begin
                            eof_cnt_q <= eof_cnt_q + 3'd1;
                        end
                    end
                    default: state_q <= StWaitIdle;
                endcase
            end
        end
    end

    assign msg_id_o     = msg_id_q;
    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign error_o      = error_q;
    assign error_code_o = error_code_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_can_bit_destuffer.sv
// Self-checking bench for can_bit_destuffer with a frame-level reference model.
module tb_can_bit_destuffer;

    localparam int unsigned CLK  = 8;
    localparam int unsigned IDLE = 11;

    logic        clock;
    logic        reset_n;
    logic        serial;
    logic [10:0] msg_id;
    logic [31:0] data;
    logic        valid;
    logic        error;
    logic [1:0]  error_code;
    logic        busy;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          n_valid = 0;
    int          n_err = 0;
    int          n_both = 0;
    logic [1:0]  last_code = 2'd3;
    int unsigned last_err_cyc = 0;
    int unsigned sof_cyc = 0;

    bit          raw_q[$];
    bit          wire_q[$];
    int          stuff_pos[$];
    int          last_crc_pos;
    int          n_stuffed;

    can_bit_destuffer #(
        .CLKS_PER_BIT (CLK),
        .IDLE_BITS    (IDLE)
    ) dut (
        .clock_i      (clock),
        .reset_i      (reset_n),
        .serial_i     (serial),
        .msg_id_o     (msg_id),
        .data_o       (data),
        .valid_o      (valid),
        .error_o      (error),
        .error_code_o (error_code),
        .busy_o       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Pulse monitor, sampled away from the active edge.
    always @(negedge clock) begin
        if (valid) n_valid++;
        if (error) begin
            n_err++;
            last_code    = error_code;
            last_err_cyc = cyc;
        end
        if (valid && error) n_both++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // CRC as the remainder of M(x)*x^15 divided by the generator, by long division.
    function automatic logic [14:0] crc_div(input int n);
        bit          m[];
        logic [15:0] g;
        logic [14:0] r;
        g = 16'hC599;
        m = new[n + 15];
        for (int i = 0; i < n; i++) m[i] = raw_q[i];
        for (int i = 0; i < n; i++) begin
            if (m[i]) begin
                for (int j = 0; j < 16; j++) m[i+j] = m[i+j] ^ g[15-j];
            end
        end
        for (int j = 0; j < 15; j++) r[14-j] = m[n+j];
        return r;
    endfunction

    task automatic build_frame(input logic [10:0] id, input logic [31:0] d, input bit flip_crc,
                               input bit ack, input bit bad_delim, input int bad_eof);
        logic [14:0] crc;
        logic [3:0]  dlc;
        int          run;
        bit          last;
        dlc = 4'd4;
        raw_q.delete();
        wire_q.delete();
        stuff_pos.delete();
        raw_q.push_back(1'b0);
        for (int i = 10; i >= 0; i--) raw_q.push_back(id[i]);
        for (int i = 0; i < 3; i++) raw_q.push_back(1'b0);
        for (int i = 3; i >= 0; i--) raw_q.push_back(dlc[i]);
        for (int i = 31; i >= 0; i--) raw_q.push_back(d[i]);
        crc = crc_div(raw_q.size());
        if (flip_crc) crc[0] = ~crc[0];
        for (int i = 14; i >= 0; i--) raw_q.push_back(crc[i]);
        run  = 0;
        last = 1'b0;
        for (int i = 0; i < raw_q.size(); i++) begin
            wire_q.push_back(raw_q[i]);
            if (i == raw_q.size() - 1) last_crc_pos = wire_q.size() - 1;
            if (run > 0 && raw_q[i] == last) run++;
            else begin
                run  = 1;
                last = raw_q[i];
            end
            if (run == 5) begin
                stuff_pos.push_back(wire_q.size());
                wire_q.push_back(~last);
                last = ~last;
                run  = 1;
            end
        end
        n_stuffed = wire_q.size();
        wire_q.push_back(bad_delim ? 1'b0 : 1'b1);
        wire_q.push_back(ack);
        wire_q.push_back(1'b1);
        for (int e = 0; e < 7; e++) wire_q.push_back((e == bad_eof) ? 1'b0 : 1'b1);
    endtask

    task automatic drive_bit(input bit b);
        serial = b;
        repeat (CLK) @(negedge clock);
    endtask

    task automatic send_range(input int lo, input int hi);
        if (lo == 0) sof_cyc = cyc;
        for (int i = lo; i <= hi; i++) drive_bit(wire_q[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b1);
    endtask

    // Error must appear after the offending bit's mid-point and before the next one's.
    task automatic check_err_time(input string tag, input int k);
        int delta;
        delta = int'(last_err_cyc) - int'(sof_cyc) - int'(CLK) * k;
        check(tag, 64'(delta >= int'(CLK / 2) && delta < int'(CLK + CLK / 2)), 64'd1);
    endtask

    initial begin
        int          v0;
        int          e0;
        int          k;
        logic [10:0] exp_id;
        logic [31:0] exp_data;
        logic [10:0] rid;
        logic [31:0] rdata;

        serial  = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_id", 64'(msg_id), 64'd0);
        check("rst_data", 64'(data), 64'd0);
        check("rst_code", 64'(error_code), 64'd0);
        reset_n = 1'b1;
        idle(14);

        // Nominal frame.
        build_frame(11'h123, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, -1);
        v0 = n_valid;
        e0 = n_err;
        send_range(0, 10);
        check("nom_busy_mid", 64'(busy), 64'd1);
        send_range(11, wire_q.size() - 1);
        idle(14);
        check("nom_valid_cnt", 64'(n_valid - v0), 64'd1);
        check("nom_err_cnt", 64'(n_err - e0), 64'd0);
        check("nom_id", 64'(msg_id), 64'h123);
        check("nom_data", 64'(data), 64'hDEADBEEF);
        check("nom_busy_end", 64'(busy), 64'd0);
        exp_id   = 11'h123;
        exp_data = 32'hDEADBEEF;

        // Flipped stuff bit.
        build_frame(11'h123, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, -1);
        k = stuff_pos[0];
        wire_q[k] = ~wire_q[k];
        v0 = n_valid;
        e0 = n_err;
        send_range(0, wire_q.size() - 1);
        idle(14);
        check("stuff_err_cnt", 64'(n_err - e0), 64'd1);
        check("stuff_code", 64'(last_code), 64'd0);
        check("stuff_valid_cnt", 64'(n_valid - v0), 64'd0);
        check_err_time("stuff_time", k);

        // Last CRC bit inverted.
        build_frame(11'h123, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, -1);
        v0 = n_valid;
        e0 = n_err;
        send_range(0, wire_q.size() - 1);
        idle(14);
        check("crc_err_cnt", 64'(n_err - e0), 64'd1);
        check("crc_code", 64'(last_code), 64'd1);
        check("crc_valid_cnt", 64'(n_valid - v0), 64'd0);
        check("crc_id_held", 64'(msg_id), 64'(exp_id));
        check("crc_data_held", 64'(data), 64'(exp_data));
        check_err_time("crc_time", last_crc_pos);

        // Dominant CRC delimiter.
        build_frame(11'h123, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, -1);
        e0 = n_err;
        send_range(0, wire_q.size() - 1);
        idle(14);
        check("delim_err_cnt", 64'(n_err - e0), 64'd1);
        check("delim_code", 64'(last_code), 64'd2);
        check_err_time("delim_time", n_stuffed);

        // Dominant 4th EOF bit.
        build_frame(11'h123, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 3);
        v0 = n_valid;
        e0 = n_err;
        send_range(0, wire_q.size() - 1);
        idle(14);
        check("eof_err_cnt", 64'(n_err - e0), 64'd1);
        check("eof_code", 64'(last_code), 64'd2);
        check("eof_valid_cnt", 64'(n_valid - v0), 64'd0);
        check_err_time("eof_time", n_stuffed + 6);

        // Random clean frames, the first of which follows the error frames.
        for (int r = 0; r < 6; r++) begin
            rid   = 11'($urandom);
            rdata = $urandom;
            build_frame(rid, rdata, 1'b0, 1'($urandom_range(0, 1)), 1'b0, -1);
            v0 = n_valid;
            e0 = n_err;
            send_range(0, wire_q.size() - 1);
            idle(14);
            check("rnd_valid_cnt", 64'(n_valid - v0), 64'd1);
            check("rnd_err_cnt", 64'(n_err - e0), 64'd0);
            check("rnd_id", 64'(msg_id), 64'(rid));
            check("rnd_data", 64'(data), 64'(rdata));
        end

        // One-cycle glitch on an idle line.
        v0 = n_valid;
        e0 = n_err;
        serial = 1'b0;
        @(negedge clock);
        serial = 1'b1;
        repeat (CLK) @(negedge clock);
        check("glitch_busy", 64'(busy), 64'd0);
        idle(3);
        check("glitch_valid_cnt", 64'(n_valid - v0), 64'd0);
        check("glitch_err_cnt", 64'(n_err - e0), 64'd0);

        // Reset during the data field, then a full frame.
        build_frame(11'h123, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, -1);
        v0 = n_valid;
        e0 = n_err;
        send_range(0, 39);
        serial  = wire_q[40];
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (CLK - 2) @(negedge clock);
        check("abort_busy", 64'(busy), 64'd0);
        send_range(41, wire_q.size() - 1);
        idle(14);
        check("abort_valid_cnt", 64'(n_valid - v0), 64'd0);
        check("abort_err_cnt", 64'(n_err - e0), 64'd0);
        v0 = n_valid;
        send_range(0, wire_q.size() - 1);
        idle(14);
        check("post_valid_cnt", 64'(n_valid - v0), 64'd1);
        check("post_id", 64'(msg_id), 64'h123);
        check("post_data", 64'(data), 64'hDEADBEEF);

        check("never_both", 64'(n_both), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
